reg_file4: RTL and testbench

REG_FILE4 -- requirements
Module: reg_file4

---
 rtl/reg_file4_if.sv | 26 ++
 rtl/reg_file4.sv | 111 +++++++++++
 tb/tb_reg_file4.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/reg_file4_if.sv
// Bus bundle for reg_file4: write port, two read ports, clear request
// and the status/strobe outputs. clk and reset stay outside the bundle.
interface reg_file4_if #(
  parameter int WIDTH = 8
);
  logic             wr_en;
  logic [1:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [1:0]       rd_addr_a;
  logic [1:0]       rd_addr_b;
  logic             clr_req;
  logic [WIDTH-1:0] rd_data_a;
  logic [WIDTH-1:0] rd_data_b;
  logic [3:0]       wr_sel;
  logic             busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
    input  rd_data_a, rd_data_b, wr_sel, busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, clr_req,
    output rd_data_a, rd_data_b, wr_sel, busy
  );
endinterface

// File: rtl/reg_file4.sv
// reg_file4: four WIDTH-bit registers, one write port, two registered
// read ports and a four-cycle sequential clear.
// Optional macro REG_FILE4_BYPASS_EN: a read port that addresses the
// register being written at the same edge captures the new write data.
module reg_file4 #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  reg_file4_if.slave  bus
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  logic [1:0]       clr_idx;
  logic             busy_q;
  logic [WIDTH-1:0] regs [4];
  logic [WIDTH-1:0] rd_a_q;
  logic [WIDTH-1:0] rd_b_q;
  logic [3:0]       wr_sel;
  logic [WIDTH-1:0] rd_a_next;
  logic [WIDTH-1:0] rd_b_next;

  // Write strobe decode; suppressed during reset and while a clear runs.
  always_comb begin
    wr_sel = '0;
    if (bus.wr_en && !busy_q && !reset) begin
      wr_sel[bus.wr_addr] = 1'b1;
    end
  end

  // Read-port source select (register contents, optionally forwarded write data).
  always_comb begin
    rd_a_next = regs[bus.rd_addr_a];
    rd_b_next = regs[bus.rd_addr_b];
`ifdef REG_FILE4_BYPASS_EN
    if (wr_sel[bus.rd_addr_a]) begin
      rd_a_next = bus.wr_data;
    end
    if (wr_sel[bus.rd_addr_b]) begin
      rd_b_next = bus.wr_data;
    end
`endif
  end

  // Clear control FSM: IDLE -> CLEAR for four edges, busy registered with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      clr_idx <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clr_req) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy_q  <= 1'b1;
          end
        end
        CLEAR: begin
          // 2-bit index wraps 3 -> 0 on the same edge that leaves CLEAR.
          clr_idx <= clr_idx + 2'd1;
          if (clr_idx == 2'd3) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Register array: clear zeroes one entry per edge, otherwise strobed writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (state == CLEAR && clr_idx == 2'(i)) begin
          regs[i] <= '0;
        end else if (wr_sel[i]) begin
          regs[i] <= bus.wr_data;
        end
      end
    end
  end

  // Registered read ports, one-cycle latency, independent addressing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= rd_a_next;
      rd_b_q <= rd_b_next;
    end
  end

  assign bus.wr_sel    = wr_sel;
  assign bus.busy      = busy_q;
  assign bus.rd_data_a = rd_a_q;
  assign bus.rd_data_b = rd_b_q;

endmodule

// File: tb/tb_reg_file4.sv
// Testbench for reg_file4: table of per-cycle vectors with expected
// strobe/read/busy values, checked through a scoreboard queue, plus a
// hand-written reset-during-clear sequence.
module tb_reg_file4;

  logic clk;
  logic reset;

  reg_file4_if #(.WIDTH(8)) bus ();

  reg_file4 #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef REG_FILE4_BYPASS_EN
  localparam logic [7:0] SAME_CYCLE_A = 8'h5A;
`else
  localparam logic [7:0] SAME_CYCLE_A = 8'h22;
`endif

  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic [1:0] ra;
    logic [1:0] rb;
    logic       clr;
    logic [3:0] sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
  } vec_t;

  vec_t tbl [21];
  vec_t sb [$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(logic we, logic [1:0] wa, logic [7:0] wd,
                              logic [1:0] ra, logic [1:0] rb, logic clr,
                              logic [3:0] sel, logic [7:0] a, logic [7:0] b,
                              logic busy);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.ra = ra; v.rb = rb; v.clr = clr;
    v.sel = sel; v.a = a; v.b = b; v.busy = busy;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [1:0] wa, input logic [7:0] wd,
                       input logic [1:0] ra, input logic [1:0] rb, input logic clr);
    bus.wr_en = we; bus.wr_addr = wa; bus.wr_data = wd;
    bus.rd_addr_a = ra; bus.rd_addr_b = rb; bus.clr_req = clr;
  endtask

  task automatic apply_vec(input int idx);
    vec_t v;
    vec_t e;
    v = tbl[idx];
    @(negedge clk);
    drive(v.we, v.wa, v.wd, v.ra, v.rb, v.clr);
    #1;
    check($sformatf("v%0d wr_sel", idx), 32'(bus.wr_sel), 32'(v.sel));
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("v%0d rd_data_a", idx), 32'(bus.rd_data_a), 32'(e.a));
    check($sformatf("v%0d rd_data_b", idx), 32'(bus.rd_data_b), 32'(e.b));
    check($sformatf("v%0d busy", idx), 32'(bus.busy), 32'(e.busy));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            we wa    wd     ra    rb    clr sel      a      b      busy
    tbl[0]  = mk(1, 2'd0, 8'h11, 2'd1, 2'd2, 0, 4'b0001, 8'h00, 8'h00, 0);
    tbl[1]  = mk(1, 2'd1, 8'h22, 2'd0, 2'd0, 0, 4'b0010, 8'h11, 8'h11, 0);
    tbl[2]  = mk(1, 2'd2, 8'h33, 2'd1, 2'd0, 0, 4'b0100, 8'h22, 8'h11, 0);
    tbl[3]  = mk(1, 2'd3, 8'h44, 2'd2, 2'd1, 0, 4'b1000, 8'h33, 8'h22, 0);
    tbl[4]  = mk(0, 2'd0, 8'h00, 2'd2, 2'd3, 0, 4'b0000, 8'h33, 8'h44, 0);
    tbl[5]  = mk(1, 2'd1, 8'h5A, 2'd1, 2'd3, 0, 4'b0010, SAME_CYCLE_A, 8'h44, 0);
    tbl[6]  = mk(0, 2'd0, 8'h00, 2'd1, 2'd1, 0, 4'b0000, 8'h5A, 8'h5A, 0);
    // clear pulse, then activity while clearing
    tbl[7]  = mk(0, 2'd0, 8'h00, 2'd0, 2'd3, 1, 4'b0000, 8'h11, 8'h44, 1);
    tbl[8]  = mk(1, 2'd3, 8'hFF, 2'd0, 2'd1, 1, 4'b0000, 8'h11, 8'h5A, 1);
    tbl[9]  = mk(0, 2'd0, 8'h00, 2'd0, 2'd1, 0, 4'b0000, 8'h00, 8'h5A, 1);
    tbl[10] = mk(1, 2'd3, 8'hFF, 2'd1, 2'd2, 1, 4'b0000, 8'h00, 8'h33, 1);
    tbl[11] = mk(0, 2'd0, 8'h00, 2'd2, 2'd3, 0, 4'b0000, 8'h00, 8'h44, 0);
    tbl[12] = mk(0, 2'd0, 8'h00, 2'd3, 2'd0, 0, 4'b0000, 8'h00, 8'h00, 0);
    tbl[13] = mk(0, 2'd0, 8'h00, 2'd1, 2'd2, 0, 4'b0000, 8'h00, 8'h00, 0);
    // simultaneous write and clear request
    tbl[14] = mk(1, 2'd0, 8'hA5, 2'd3, 2'd3, 0, 4'b0001, 8'h00, 8'h00, 0);
    tbl[15] = mk(1, 2'd2, 8'h77, 2'd0, 2'd3, 1, 4'b0100, 8'hA5, 8'h00, 1);
    tbl[16] = mk(0, 2'd0, 8'h00, 2'd2, 2'd0, 0, 4'b0000, 8'h77, 8'hA5, 1);
    tbl[17] = mk(0, 2'd0, 8'h00, 2'd2, 2'd0, 0, 4'b0000, 8'h77, 8'h00, 1);
    tbl[18] = mk(0, 2'd0, 8'h00, 2'd2, 2'd1, 0, 4'b0000, 8'h77, 8'h00, 1);
    tbl[19] = mk(0, 2'd0, 8'h00, 2'd2, 2'd0, 0, 4'b0000, 8'h00, 8'h00, 0);
    tbl[20] = mk(0, 2'd0, 8'h00, 2'd2, 2'd2, 0, 4'b0000, 8'h00, 8'h00, 0);

    // reset state, with a write request held to show it is blocked
    reset = 1'b1;
    drive(1, 2'd2, 8'h99, 2'd0, 2'd0, 0);
    #3;
    check("reset wr_sel", 32'(bus.wr_sel), 32'h0);
    check("reset rd_data_a", 32'(bus.rd_data_a), 32'h0);
    check("reset rd_data_b", 32'(bus.rd_data_b), 32'h0);
    check("reset busy", 32'(bus.busy), 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 2'd0, 8'h00, 2'd2, 2'd2, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("post-reset R2", 32'(bus.rd_data_a), 32'h0);

    for (int i = 0; i < 21; i++) begin
      apply_vec(i);
    end

    // reset two cycles into a clear: R3 is written first so the clear
    // would not yet have reached it
    @(negedge clk);
    drive(1, 2'd3, 8'h66, 2'd0, 2'd0, 0);
    @(negedge clk);
    drive(0, 2'd0, 8'h00, 2'd3, 2'd3, 1);
    @(posedge clk);
    #1;
    check("mid-clear start busy", 32'(bus.busy), 32'h1);
    check("mid-clear R3 before", 32'(bus.rd_data_a), 32'h66);
    @(negedge clk);
    drive(1, 2'd1, 8'hEE, 2'd3, 2'd3, 0);
    @(posedge clk);
    #1;
    check("mid-clear second busy", 32'(bus.busy), 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid-clear reset busy", 32'(bus.busy), 32'h0);
    check("mid-clear reset rd_data_a", 32'(bus.rd_data_a), 32'h0);
    check("mid-clear reset rd_data_b", 32'(bus.rd_data_b), 32'h0);
    check("mid-clear reset wr_sel", 32'(bus.wr_sel), 32'h0);
    @(negedge clk);
    drive(0, 2'd0, 8'h00, 2'd3, 2'd1, 0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      check($sformatf("after-abort c%0d busy", c), 32'(bus.busy), 32'h0);
      check($sformatf("after-abort c%0d R3", c), 32'(bus.rd_data_a), 32'h0);
      check($sformatf("after-abort c%0d R1", c), 32'(bus.rd_data_b), 32'h0);
    end

    if (sb.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard drain: got %0d left, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
